// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/read handshake and sticky framing/overrun flags.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 majority sampling.
module uart_rx #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       read_en,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int BAUD_CNT_MAX = (CLK_FREQ / BAUD) - 1;
  localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX + 1);

`ifdef UART_RX_MAJORITY_EN
  // Decision waits one clock so the +1 sample exists; every later point inherits the shift.
  localparam int START_PT = HALF_CNT + 1;
`else
  localparam int START_PT = HALF_CNT;
`endif

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(BAUD_CNT_MAX);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shift_reg, shift_reg_d;
  logic             rx_s1, rx_s2, rx_prev;
  logic             sample;
  logic             frame_good, frame_bad;
  logic             read_hit, deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_d2 <= 1'b0;
    else        rx_d2 <= rx_prev;
  end

  assign sample = (rx_d2 & rx_prev) | (rx_d2 & rx_s2) | (rx_prev & rx_s2);
`else
  assign sample = rx_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shift_reg <= shift_reg_d;
    end
  end

  always_comb begin
    state_d     = state;
    baud_cnt_d  = baud_cnt;
    bit_cnt_d   = bit_cnt;
    shift_reg_d = shift_reg;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s2) begin
          state_d    = START;
          baud_cnt_d = '0;
        end
      end
      START: begin
        if (baud_cnt == START_CNT) begin
          baud_cnt_d = '0;
          if (!sample) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_CNT) begin
          baud_cnt_d  = '0;
          shift_reg_d = {sample, shift_reg[7:1]};
          if (bit_cnt == 3'd7) state_d = STOP;
          else                 bit_cnt_d = bit_cnt + 1'b1;
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_CNT) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          frame_good = sample;
          frame_bad  = !sample;
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_hit = read_en && data_valid;
  assign deliver  = frame_good && (!data_valid || read_en);

  // A new event on the same edge as a read wins over the read's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (deliver) data <= shift_reg;

      if (deliver)       data_valid <= 1'b1;
      else if (read_hit) data_valid <= 1'b0;

      if (frame_good && data_valid && !read_en) overrun <= 1'b1;
      else if (read_hit)                        overrun <= 1'b0;

      if (frame_bad)     framing_error <= 1'b1;
      else if (read_hit) framing_error <= 1'b0;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected register snapshots,
// a monitor compares them whenever a frame ends or data_valid drops.
module tb_uart_rx;

  localparam int CLK_FREQ     = 1_000_000;
  localparam int BAUD         = 10_000;
  localparam int BIT          = CLK_FREQ / BAUD;
  localparam int HALF         = (BIT - 1) / 2;
  localparam int NO_READ      = -1;
  localparam int READ_AT_STOP = -2;
`ifdef UART_RX_MAJORITY_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       read_en = 1'b0;
  logic [7:0] data;
  logic       data_valid, framing_error, overrun, rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .read_en(read_en),
    .data(data), .data_valid(data_valid), .framing_error(framing_error),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  typedef logic [10:0] snap_t;
  snap_t exp_q[$];
  string name_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_data = 8'h00;
  logic m_dv = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push(input string nm);
    exp_q.push_back({m_data, m_dv, m_fe, m_ov});
    name_q.push_back(nm);
  endtask

  // Monitor
  logic  busy_q = 1'b0, dv_q = 1'b0;
  snap_t mon_exp;
  string mon_nm;
  always @(negedge clk) begin
    if ((busy_q && !rx_busy) || (dv_q && !data_valid)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got %h expected no event",
                 {data, data_valid, framing_error, overrun});
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        check(mon_nm, {21'h0, data, data_valid, framing_error, overrun}, {21'h0, mon_exp});
      end
    end
    busy_q = rx_busy;
    dv_q   = data_valid;
  end

  task automatic do_read(input string nm);
    if (m_dv) begin
      m_dv = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
      push(nm);
    end
    @(negedge clk) read_en = 1'b1;
    @(negedge clk) read_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input logic [7:0] exp_b, input bit stop_ok,
                       input bit spike, input int read_j, input int abort_j,
                       input int idle, input string nm);
    logic [9:0] bits;
    bit coincide;
    bits = {stop_ok, b, 1'b0};
    coincide = (read_j == READ_AT_STOP);
    if (read_j >= 0 && m_dv) begin
      m_dv = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
      push({nm, "_rd"});
    end
    if (abort_j >= 0) begin
      m_data = 8'h00; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      push({nm, "_rst"});
    end else begin
      if (coincide && m_dv) begin
        m_ov = 1'b0; m_fe = 1'b0;
      end
      if (stop_ok) begin
        if (!m_dv || coincide) begin
          m_data = exp_b; m_dv = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else begin
        m_fe = 1'b1;
      end
      push(nm);
    end
    for (int j = 0; j < 10 * BIT; j++) begin
      @(negedge clk);
      if (j == abort_j) begin
        #2 rst_n = 1'b0;
        rx = 1'b1;
        read_en = 1'b0;
        break;
      end
      rx = bits[j / BIT];
      if (spike && (j / BIT) >= 1 && (j / BIT) <= 8 && (j % BIT) == HALF + 1) rx = ~rx;
      read_en = (j == read_j) || (coincide && j == HALF + 3 + 9 * BIT + M);
    end
    repeat (idle) begin
      @(negedge clk);
      rx = 1'b1;
      read_en = 1'b0;
    end
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: run still active, required finish before cycle limit");
    $fatal(1);
  end

  initial begin
    int busy_seen;
    repeat (5) @(negedge clk);
    check("reset", {20'h0, data, data_valid, framing_error, overrun, rx_busy}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic bytes
    frame(8'h55, 8'h55, 1, 0, NO_READ, -1, 20, "b55");
    do_read("rd55");
    frame(8'hA3, 8'hA3, 1, 0, NO_READ, -1, 20, "bA3");
    do_read("rdA3");

    // Back-to-back, each read during the following frame
    frame(8'h00, 8'h00, 1, 0, NO_READ, -1, 0, "bb00");
    frame(8'hFF, 8'hFF, 1, 0, 200, -1, 0, "bbFF");
    frame(8'h81, 8'h81, 1, 0, 200, -1, 20, "bb81");
    do_read("rd81");

    // Framing error then a good byte and clearing read
    frame(8'h3C, 8'h3C, 0, 0, NO_READ, -1, 20, "fe3C");
    frame(8'hC5, 8'hC5, 1, 0, NO_READ, -1, 20, "afterfeC5");
    do_read("rdC5");

    // Overrun, then completion coinciding with read_en
    frame(8'h11, 8'h11, 1, 0, NO_READ, -1, 20, "ov11");
    frame(8'h22, 8'h22, 1, 0, NO_READ, -1, 20, "ov22");
    frame(8'h33, 8'h33, 1, 0, READ_AT_STOP, -1, 20, "coin33");
    do_read("rd33");

    // Short low glitch: FSM must abandon the start with nothing changed
    push("glitch");
    repeat (20) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk) rx = 1'b1;
    repeat (BIT) @(negedge clk);

    // Reset during DATA of 0x5A with a byte pending
    frame(8'h77, 8'h77, 1, 0, NO_READ, -1, 20, "b77");
    frame(8'h5A, 8'h5A, 1, 0, NO_READ, 400, 0, "abort5A");
    repeat (5) @(negedge clk);
    rx = 1'b0;
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (rx_busy) busy_seen++;
    end
    check("held_low_busy", busy_seen, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    frame(8'h5A, 8'h5A, 1, 0, NO_READ, -1, 20, "recover5A");
    do_read("rd5A");

    // Spike at every data sample point
`ifdef UART_RX_MAJORITY_EN
    frame(8'h96, 8'h96, 1, 1, NO_READ, -1, 20, "spike96");
`else
    frame(8'h96, 8'h69, 1, 1, NO_READ, -1, 20, "spike96");
`endif
    do_read("rd96");

    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
